// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory, applies ID
// redirects and feeds IF/ID through a 1-entry skid buffer. Optional counters: IF_PERF_CNT_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hold,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstructionIF,
  output logic [31:0] PC4IF,
  output logic        if_valid,
  output logic        flush
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] wait_cnt,
  output logic [31:0] redir_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, FULL, DISCARD} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] redir_pc;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc4;
  logic [31:0] pc_next;
  logic [31:0] target;
  logic        redir_act;
  logic        consume;

  // A redirect presented during a stall is ignored; ID re-presents it afterwards.
  assign redir_act = (branch_taken | jump) & ~hold;
  assign target    = branch_taken ? branch_target : jump_target;
  assign consume   = ~hold;
  assign flush     = redir_act;
  assign imem_addr = fetch_pc;
  assign pc_next   = fetch_pc + 32'd4;

  // NOTE: all state below uses non-blocking assignments so every branch of the case
  // reads pre-edge values, exactly like the flops it describes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      imem_req      <= 1'b0;
      fetch_pc      <= RESET_PC;
      redir_pc      <= RESET_PC;
      skid_instr    <= '0;
      skid_pc4      <= '0;
      InstructionIF <= '0;
      PC4IF         <= '0;
      if_valid      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end

        FETCH: begin
          if (redir_act) begin
            InstructionIF <= '0;
            PC4IF         <= '0;
            if_valid      <= 1'b0;
            if (imem_ready) begin
              fetch_pc <= target;
            end else begin
              // The in-flight request must still complete before the new PC is used.
              redir_pc <= target;
              state    <= DISCARD;
            end
          end else if (imem_ready) begin
            fetch_pc <= pc_next;
            if (!if_valid || consume) begin
              InstructionIF <= imem_rdata;
              PC4IF         <= pc_next;
              if_valid      <= 1'b1;
            end else begin
              skid_instr <= imem_rdata;
              skid_pc4   <= pc_next;
              imem_req   <= 1'b0;
              state      <= FULL;
            end
          end else if (consume) begin
            InstructionIF <= '0;
            PC4IF         <= '0;
            if_valid      <= 1'b0;
          end
        end

        FULL: begin
          if (redir_act) begin
            InstructionIF <= '0;
            PC4IF         <= '0;
            if_valid      <= 1'b0;
            fetch_pc      <= target;
            imem_req      <= 1'b1;
            state         <= FETCH;
          end else if (consume) begin
            InstructionIF <= skid_instr;
            PC4IF         <= skid_pc4;
            if_valid      <= 1'b1;
            imem_req      <= 1'b1;
            state         <= FETCH;
          end
        end

        DISCARD: begin
          if (redir_act) redir_pc <= target;
          if (imem_ready) begin
            fetch_pc <= redir_act ? target : redir_pc;
            state    <= FETCH;
          end
        end

        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic fetch_done;
  logic redir_done;

  assign fetch_done = (state == FETCH) & imem_ready & ~redir_act;
  assign redir_done = redir_act & (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt <= '0;
      wait_cnt  <= '0;
      redir_cnt <= '0;
    end else begin
      fetch_cnt <= fetch_cnt + {31'b0, fetch_done};
      wait_cnt  <= wait_cnt + {31'b0, imem_req & ~imem_ready};
      redir_cnt <= redir_cnt + {31'b0, redir_done};
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios, then randomized hold/ready/redirect traffic
// scored against a program-order model of what IF/ID must capture.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hold;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] InstructionIF;
  logic [31:0] PC4IF;
  logic        if_valid;
  logic        flush;

  int          checks = 0;
  int          errors = 0;
  int          captures = 0;
  logic [31:0] exp_pc = RESET_PC;
  bit          prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .hold         (hold),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .InstructionIF(InstructionIF),
    .PC4IF        (PC4IF),
    .if_valid     (if_valid),
    .flush        (flush)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction memory contents: word index of the address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a >> 2;
  endfunction

  // One clock: memory answers, invariants and the IF/ID capture model are checked
  // just before the rising edge; returns at the following falling edge.
  task automatic cycle();
    imem_rdata = imem_ready ? mem_f(imem_addr) : 32'hDEAD_BEEF;
    #1;
    if (!if_valid) begin
      check("nop_instr", InstructionIF, 32'h0);
      check("nop_pc4", PC4IF, 32'h0);
    end
    check("flush", 32'(flush), 32'((branch_taken | jump) & ~hold));
    if (prev_wait) check("addr_stable", imem_addr, prev_addr);
    if (!hold && (branch_taken || jump)) begin
      exp_pc = branch_taken ? branch_target : jump_target;
    end else if (!hold && if_valid) begin
      check("cap_pc4", PC4IF, exp_pc + 32'd4);
      check("cap_instr", InstructionIF, mem_f(exp_pc));
      exp_pc = exp_pc + 32'd4;
      captures++;
    end
    prev_wait = imem_req & ~imem_ready;
    prev_addr = imem_addr;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle, checks outputs clear at once, releases on a falling edge.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_instr", InstructionIF, 32'h0);
    check("rst_pc4", PC4IF, 32'h0);
    check("rst_addr", imem_addr, RESET_PC);
    @(negedge clk);
    @(negedge clk);
    reset_n   = 1'b1;
    exp_pc    = RESET_PC;
    prev_wait = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    hold          = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    jump          = 1'b0;
    jump_target   = '0;
    imem_ready    = 1'b1;
    imem_rdata    = '0;
    @(negedge clk);
    do_reset();

    // Back-to-back fetch after reset: one IDLE cycle, then one instruction per cycle.
    check("idle_req", 32'(imem_req), 32'h0);
    cycle();
    check("t1_req", 32'(imem_req), 32'h1);
    check("t1_addr0", imem_addr, 32'h0);
    check("t1_valid0", 32'(if_valid), 32'h0);
    cycle();
    check("t1_pc4_a", PC4IF, 32'h4);
    check("t1_instr_a", InstructionIF, 32'h0);
    cycle();
    check("t1_pc4_b", PC4IF, 32'h8);
    check("t1_instr_b", InstructionIF, 32'h1);
    check("t1_addr_b", imem_addr, 32'h8);

    // Memory stall on 0x8.
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'b0;
      cycle();
      check("t2_addr", imem_addr, 32'h8);
      check("t2_valid", 32'(if_valid), 32'h0);
    end
    imem_ready = 1'b1;
    cycle();
    check("t2_pc4", PC4IF, 32'hC);
    check("t2_instr", InstructionIF, 32'h2);

    // IF/ID hold: one extra fetch goes to the skid, then requests stop.
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t3_req", 32'(imem_req), 32'h0);
      check("t3_pc4", PC4IF, 32'hC);
      check("t3_instr", InstructionIF, 32'h2);
    end
    hold = 1'b0;
    cycle();
    check("t3_skid_pc4", PC4IF, 32'h10);
    check("t3_skid_instr", InstructionIF, 32'h3);
    check("t3_addr", imem_addr, 32'h10);
    cycle();
    check("t3_next_pc4", PC4IF, 32'h14);

    // Branch while the memory is waiting.
    imem_ready = 1'b0;
    cycle();
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    #1;
    check("t4_flush", 32'(flush), 32'h1);
    cycle();
    branch_taken = 1'b0;
    check("t4_disc_addr", imem_addr, 32'h14);
    check("t4_disc_req", 32'(imem_req), 32'h1);
    imem_ready = 1'b1;
    cycle();
    check("t4_new_addr", imem_addr, 32'h100);
    check("t4_valid", 32'(if_valid), 32'h0);
    cycle();
    check("t4_pc4", PC4IF, 32'h104);
    check("t4_instr", InstructionIF, 32'h40);

    // Branch and jump together, first held, then re-presented.
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    jump          = 1'b1;
    jump_target   = 32'h300;
    hold          = 1'b1;
    #1;
    check("t5_held_flush", 32'(flush), 32'h0);
    cycle();
    check("t5_held_pc4", PC4IF, 32'h104);
    hold = 1'b0;
    #1;
    check("t5_flush", 32'(flush), 32'h1);
    cycle();
    branch_taken = 1'b0;
    jump         = 1'b0;
    check("t5_addr", imem_addr, 32'h200);
    cycle();
    check("t5_pc4", PC4IF, 32'h204);
    check("t5_instr", InstructionIF, 32'h80);

    // Reset in the middle of a discarded transfer.
    imem_ready  = 1'b0;
    jump        = 1'b1;
    jump_target = 32'h400;
    cycle();
    jump = 1'b0;
    check("t6_disc_req", 32'(imem_req), 32'h1);
    check("t6_disc_valid", 32'(if_valid), 32'h0);
    do_reset();
    imem_ready = 1'b1;
    check("t6_idle_req", 32'(imem_req), 32'h0);
    cycle();
    check("t6_restart", imem_addr, RESET_PC);

    // PC wraps past the top of the address space.
    jump        = 1'b1;
    jump_target = 32'hFFFF_FFFC;
    cycle();
    jump = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cycle();
    check("wrap_valid", 32'(if_valid), 32'h1);
    check("wrap_pc4", PC4IF, 32'h0);
    check("wrap_instr", InstructionIF, 32'h3FFF_FFFF);
    check("wrap_next_addr", imem_addr, 32'h0);

    // Randomized traffic.
    captures = 0;
    for (int c = 0; c < 3000; c++) begin
      hold         = ($urandom_range(0, 3) == 0);
      imem_ready   = ($urandom_range(0, 9) < 7);
      branch_taken = 1'b0;
      jump         = 1'b0;
      if ((imem_req || if_valid) && $urandom_range(0, 11) == 0) begin
        branch_taken  = 1'($urandom_range(0, 1));
        jump          = 1'($urandom_range(0, 1));
        if (!branch_taken && !jump) jump = 1'b1;
        branch_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
        jump_target   = $urandom() & 32'hFFFF_FFFC;
      end
      cycle();
    end
    branch_taken = 1'b0;
    jump         = 1'b0;
    check("progress", 32'(captures >= 300), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
